// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-access codes produced
// by the decoder, the LSU state encoding and the alignment rule.
package ysyx_23060240_lsu_pkg;

  // Load codes (rd_ctrl), shared with the instruction decoder
  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b001;
  localparam logic [2:0] RD_LBU  = 3'b010;
  localparam logic [2:0] RD_LH   = 3'b011;
  localparam logic [2:0] RD_LHU  = 3'b100;
  localparam logic [2:0] RD_LW   = 3'b101;

  // Store codes (wr_ctrl), shared with the instruction decoder
  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Halfword accesses need an even address, word accesses a multiple of four;
  // byte accesses can never be misaligned.
  function automatic logic isMisaligned(input logic [2:0] rdCtrl,
                                        input logic [1:0] wrCtrl,
                                        input logic [1:0] offset);
    logic isHalf;
    logic isWord;
    isHalf = (rdCtrl == RD_LH) || (rdCtrl == RD_LHU) || (wrCtrl == WR_SH);
    isWord = (rdCtrl == RD_LW) || (wrCtrl == WR_SW);
    return (isHalf && offset[0]) || (isWord && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_rext.sv
// Load-data extractor: picks the addressed byte or halfword out of the bus
// word and sign- or zero-extends it to 32 bits.
module ysyx_23060240_lsu_rext
  import ysyx_23060240_lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  rdCtrl_i,
  output logic [31:0] ext_o
);

  logic [7:0]  byteVal;
  logic [15:0] halfVal;

  // Select the byte lane and halfword lane addressed by the low address bits
  always_comb begin
    byteVal = 8'h00;
    case (offset_i)
      2'd0:    byteVal = rdata_i[7:0];
      2'd1:    byteVal = rdata_i[15:8];
      2'd2:    byteVal = rdata_i[23:16];
      default: byteVal = rdata_i[31:24];
    endcase
    halfVal = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extend the selected lane according to the load code
  always_comb begin
    ext_o = 32'h0;
    case (rdCtrl_i)
      RD_LB:   ext_o = {{24{byteVal[7]}}, byteVal};
      RD_LBU:  ext_o = {24'h0, byteVal};
      RD_LH:   ext_o = {{16{halfVal[15]}}, halfVal};
      RD_LHU:  ext_o = {16'h0, halfVal};
      RD_LW:   ext_o = rdata_i;
      default: ext_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Load/store unit: accepts one access from execute, checks it, issues a
// word-aligned byte-masked bus transaction and returns an extended result.
module ysyx_23060240_lsu
  import ysyx_23060240_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  rd_ctrl,
  input  logic [1:0]  wr_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  rdCtrl_q, rdCtrl_d;
  logic [1:0]  wrCtrl_q, wrCtrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] extWord;
  logic        reqIllegal;
  logic        inReq;

  ysyx_23060240_lsu_rext u_rext (
    .rdata_i  (mem_rdata),
    .offset_i (addr_q[1:0]),
    .rdCtrl_i (rdCtrl_q),
    .ext_o    (extWord)
  );

  // A request is rejected if it names an undefined load code, asks for a
  // load and a store at once, or is misaligned for its access size.
  always_comb begin
    reqIllegal = (rd_ctrl > RD_LW)
              || ((rd_ctrl != RD_NONE) && (wr_ctrl != WR_NONE))
              || isMisaligned(rd_ctrl, wr_ctrl, addr[1:0]);
  end

  // State and captured-request registers; reset drops any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdCtrl_q <= RD_NONE;
      wrCtrl_q <= WR_NONE;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdCtrl_q <= rdCtrl_d;
      wrCtrl_q <= wrCtrl_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic: capture in IDLE, hold the bus request until accepted,
  // catch read data only in WAIT, hold the response until consumed.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdCtrl_d = rdCtrl_q;
    wrCtrl_d = wrCtrl_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d   = addr;
          wdata_d  = wdata;
          rdCtrl_d = rd_ctrl;
          wrCtrl_d = wr_ctrl;
          rdata_d  = 32'h0;
          err_d    = 1'b0;
          if ((rd_ctrl == RD_NONE) && (wr_ctrl == WR_NONE)) begin
            state_d = ST_RESP;
          end else if (reqIllegal) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = (wrCtrl_q != WR_NONE) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = extWord;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; bus and response fields are driven only in the state
  // that owns them and read zero elsewhere.
  always_comb begin
    inReq         = (state_q == ST_REQ);
    req_ready     = (state_q == ST_IDLE);
    mem_req_valid = inReq;
    mem_we        = inReq && (wrCtrl_q != WR_NONE);
    mem_addr      = inReq ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_wmask     = 4'b0000;
    mem_wdata     = 32'h0;
    if (inReq) begin
      case (wrCtrl_q)
        WR_SB: begin
          mem_wmask = 4'b0001 << addr_q[1:0];
          mem_wdata = {4{wdata_q[7:0]}};
        end
        WR_SH: begin
          mem_wmask = 4'b0011 << addr_q[1:0];
          mem_wdata = {2{wdata_q[15:0]}};
        end
        WR_SW: begin
          mem_wmask = 4'b1111;
          mem_wdata = wdata_q;
        end
        default: begin
          mem_wmask = 4'b0000;
          mem_wdata = 32'h0;
        end
      endcase
    end
    resp_valid = (state_q == ST_RESP);
    resp_rdata = (state_q == ST_RESP) ? rdata_q : 32'h0;
    resp_err   = (state_q == ST_RESP) && err_q;
  end

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Self-checking bench for the load/store unit: directed cases followed by
// randomized accesses compared against a behavioural model.
module tb_ysyx_23060240_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  rd_ctrl;
  logic [1:0]  wr_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  ysyx_23060240_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .rd_ctrl       (rd_ctrl),
    .wr_ctrl       (wr_ctrl),
    .addr          (addr),
    .wdata         (wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: access size from the code, error if undefined,
  // combined or misaligned, lanes by arithmetic on the byte offset.
  function automatic void refModel(input logic [2:0] rc, input logic [1:0] wc,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] word,
                                   output logic expErr, output logic expBus,
                                   output logic expWe, output logic [3:0] expMask,
                                   output logic [31:0] expWdata,
                                   output logic [31:0] expRdata);
    int size;
    int off;
    int bits;
    logic [31:0] v;
    logic [31:0] lowMask;
    off  = int'(a[1:0]);
    size = 0;
    case (rc)
      3'd1, 3'd2: size = 1;
      3'd3, 3'd4: size = 2;
      3'd5:       size = 4;
      default:    size = 0;
    endcase
    case (wc)
      2'd1:    size = 1;
      2'd2:    size = 2;
      2'd3:    size = 4;
      default: ;
    endcase
    expErr = (rc > 3'd5) || ((rc != 0) && (wc != 0))
          || ((size > 0) && ((off % size) != 0));
    expBus = !expErr && ((rc != 0) || (wc != 0));
    expWe  = expBus && (wc != 0);
    expMask  = 4'b0000;
    expWdata = 32'h0;
    expRdata = 32'h0;
    if (expWe) begin
      expMask = 4'(((1 << size) - 1) << off);
      if (size == 1)      expWdata = {24'h0, wd[7:0]} * 32'h0101_0101;
      else if (size == 2) expWdata = {16'h0, wd[15:0]} * 32'h0001_0001;
      else                expWdata = wd;
    end else if (expBus) begin
      bits = 8 * size;
      v = word >> (8 * (off - (off % size)));
      if (size < 4) begin
        lowMask = (32'd1 << bits) - 32'd1;
        v = v & lowMask;
        if (((rc == 3'd1) || (rc == 3'd3)) && v[bits-1]) v = v | ~lowMask;
      end
      expRdata = v;
    end
  endfunction

  // Runs one complete access, playing the memory and the response consumer,
  // and checks timing, bus fields and the response against the model.
  task automatic applyStimulus(input logic [2:0] rc, input logic [1:0] wc,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] word, input int reqDelay,
                               input int rvDelay, input int respDelay);
    logic        eErr, eBus, eWe;
    logic [3:0]  eMask;
    logic [31:0] eWd, eRd, eAddr;
    refModel(rc, wc, a, wd, word, eErr, eBus, eWe, eMask, eWd, eRd);
    eAddr = {a[31:2], 2'b00};
    checkOutput("idle_req_ready", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1;
    rd_ctrl   = rc;
    wr_ctrl   = wc;
    addr      = a;
    wdata     = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rd_ctrl   = 3'($urandom);
    wr_ctrl   = 2'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
    checkOutput("busy_req_ready", {31'h0, req_ready}, 32'd0);
    checkOutput("req_valid_t1", {31'h0, mem_req_valid}, {31'h0, eBus});
    if (eBus) begin
      for (int i = 0; i <= reqDelay; i++) begin
        checkOutput("req_hold_valid", {31'h0, mem_req_valid}, 32'd1);
        checkOutput("req_addr", mem_addr, eAddr);
        checkOutput("req_we", {31'h0, mem_we}, {31'h0, eWe});
        checkOutput("req_wmask", {28'h0, mem_wmask}, {28'h0, eMask});
        checkOutput("req_wdata", mem_wdata, eWd);
        checkOutput("req_no_resp", {31'h0, resp_valid}, 32'd0);
        if (i == reqDelay) begin
          mem_req_ready = 1'b1;
        end else if (i == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = $urandom;
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
      end
      if (!eWe) begin
        for (int i = 0; i < rvDelay; i++) begin
          checkOutput("wait_no_bus", {31'h0, mem_req_valid}, 32'd0);
          checkOutput("wait_no_resp", {31'h0, resp_valid}, 32'd0);
          @(posedge clk); #1;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
      end
    end
    for (int i = 0; i <= respDelay; i++) begin
      checkOutput("resp_valid", {31'h0, resp_valid}, 32'd1);
      checkOutput("resp_err", {31'h0, resp_err}, {31'h0, eErr});
      checkOutput("resp_rdata", resp_rdata, eRd);
      checkOutput("resp_req_ready", {31'h0, req_ready}, 32'd0);
      checkOutput("resp_no_bus", {31'h0, mem_req_valid}, 32'd0);
      if (i == respDelay) resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
    checkOutput("done_resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("done_req_ready", {31'h0, req_ready}, 32'd1);
  endtask

  // Reset checks, directed cases, reset during WAIT, then random traffic
  initial begin
    logic [2:0]  rc;
    logic [1:0]  wc;
    rst           = 1'b1;
    req_valid     = 1'b0;
    rd_ctrl       = 3'd0;
    wr_ctrl       = 2'd0;
    addr          = 32'h0;
    wdata         = 32'h0;
    resp_ready    = 1'b0;
    mem_req_ready = 1'b0;
    mem_rvalid    = 1'b0;
    mem_rdata     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(3'd0, 2'd1, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0);
    applyStimulus(3'd1, 2'd0, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 0, 0);
    applyStimulus(3'd2, 2'd0, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 1, 0);
    applyStimulus(3'd4, 2'd0, 32'h8000_0002, 32'h0, 32'h1280_3456, 1, 0, 0);
    applyStimulus(3'd5, 2'd0, 32'h8000_0002, 32'h0, 32'h1280_3456, 0, 0, 0);
    applyStimulus(3'd5, 2'd3, 32'h8000_0000, 32'h1234_5678, 32'h0, 0, 0, 0);
    applyStimulus(3'd6, 2'd0, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0);
    applyStimulus(3'd0, 2'd0, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 1);
    applyStimulus(3'd0, 2'd2, 32'h8000_0004, 32'hCAFE_BEEF, 32'h0, 5, 0, 0);
    applyStimulus(3'd5, 2'd0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 0, 0, 3);

    // reset asserted while the LSU waits for read data
    req_valid = 1'b1;
    rd_ctrl   = 3'd5;
    wr_ctrl   = 2'd0;
    addr      = 32'h8000_0010;
    @(posedge clk); #1;
    req_valid     = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    checkOutput("wait_before_rst", {31'h0, resp_valid}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_req_ready", {31'h0, req_ready}, 32'd1);
    checkOutput("arst_resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("arst_mem_req_valid", {31'h0, mem_req_valid}, 32'd0);
    checkOutput("arst_mem_addr", mem_addr, 32'h0);
    checkOutput("arst_resp_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("late_rvalid_ignored", {31'h0, resp_valid}, 32'd0);
      checkOutput("late_rvalid_idle", {31'h0, req_ready}, 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(3'd5, 2'd0, 32'h8000_0010, 32'h0, 32'h0BAD_F00D, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      rc = 3'($urandom_range(0, 7));
      wc = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 8) begin
        if ($urandom_range(0, 1) == 1) rc = 3'd0;
        else wc = 2'd0;
        if (rc > 3'd5) rc = 3'($urandom_range(1, 5));
      end
      applyStimulus(rc, wc, $urandom, $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
